// File: rtl/nx_constants_pkg.sv
// Shared message type and source encodings for the nx stream fabric.
// Both inputs and the host side of the combiner exchange nx_message_t words.
package nx_constants;

  typedef logic [31:0] nx_message_t;

  typedef enum logic {
    NX_SRC_CTRL = 1'b0,
    NX_SRC_MESH = 1'b1
  } nx_source_e;

endpackage

// File: rtl/nx_stream_combiner_if.sv
// Handshake bundle for nx_stream_combiner: two producer streams in, one host stream out.
// The slave modport is the combiner's view; the master modport is the environment's view.
interface nx_stream_combiner_if;
  import nx_constants::*;

  nx_message_t ctrl_data_i;
  logic        ctrl_valid_i;
  logic        ctrl_ready_o;
  nx_message_t mesh_data_i;
  logic        mesh_valid_i;
  logic        mesh_ready_o;
  nx_message_t host_data_o;
  nx_source_e  host_source_o;
  logic        host_valid_o;
  logic        host_ready_i;
  logic        idle_o;

  modport slave (
    input  ctrl_data_i, ctrl_valid_i, mesh_data_i, mesh_valid_i, host_ready_i,
    output ctrl_ready_o, mesh_ready_o, host_data_o, host_source_o, host_valid_o, idle_o
  );

  modport master (
    output ctrl_data_i, ctrl_valid_i, mesh_data_i, mesh_valid_i, host_ready_i,
    input  ctrl_ready_o, mesh_ready_o, host_data_o, host_source_o, host_valid_o, idle_o
  );

endinterface

// File: rtl/nx_fifo.sv
// First-word-fall-through FIFO with wrap-bit pointers; head is visible on data_o while not empty.
// Pushes into a full FIFO and pops from an empty FIFO are ignored.
module nx_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic             w_push;
  logic             w_pop;

  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  assign empty_o = (r_wr_ptr == r_rd_ptr);
  assign full_o  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign data_o  = r_mem[r_rd_ptr[AW-1:0]];

  // NOTE: state registers use <= so every flop samples pre-edge values regardless of block order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are live.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/nx_stream_combiner.sv
// Merges ctrl and mesh message streams into one registered host slot with per-source FIFOs.
// Define NX_COMBINER_CTRL_PRIORITY_EN for strict ctrl priority on ties instead of round-robin.
module nx_stream_combiner
  import nx_constants::*;
#(
  parameter int FIFO_DEPTH  = 2,
  parameter int STALL_LIMIT = 255
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  nx_stream_combiner_if.slave  bus
);

  localparam int              WAIT_W   = $clog2(STALL_LIMIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STALL_LIMIT);

  logic              r_ready_en;
  nx_message_t       w_ctrl_head;
  nx_message_t       w_mesh_head;
  logic              w_ctrl_full, w_ctrl_empty, w_mesh_full, w_mesh_empty;
  logic              w_ctrl_ready, w_mesh_ready;
  logic              w_ctrl_push, w_mesh_push, w_ctrl_pop, w_mesh_pop;
  logic              w_load, w_any, w_fire;
  nx_source_e        w_grant, w_tie_grant;
  logic              r_host_valid;
  nx_message_t       r_host_data;
  nx_source_e        r_host_source;
  nx_source_e        r_last_grant;
  logic [WAIT_W-1:0] r_ctrl_wait, r_mesh_wait;

  // Ready is held low through reset and for the release edge, then tracks FIFO space only.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_ready_en <= 1'b0;
    else       r_ready_en <= 1'b1;
  end

  assign w_ctrl_ready = r_ready_en & ~w_ctrl_full;
  assign w_mesh_ready = r_ready_en & ~w_mesh_full;
  assign w_ctrl_push  = bus.ctrl_valid_i & w_ctrl_ready;
  assign w_mesh_push  = bus.mesh_valid_i & w_mesh_ready;

  nx_fifo #(.WIDTH($bits(nx_message_t)), .DEPTH(FIFO_DEPTH)) u_ctrl_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_ctrl_push),
    .data_i  (bus.ctrl_data_i),
    .pop_i   (w_ctrl_pop),
    .data_o  (w_ctrl_head),
    .full_o  (w_ctrl_full),
    .empty_o (w_ctrl_empty)
  );

  nx_fifo #(.WIDTH($bits(nx_message_t)), .DEPTH(FIFO_DEPTH)) u_mesh_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_mesh_push),
    .data_i  (bus.mesh_data_i),
    .pop_i   (w_mesh_pop),
    .data_o  (w_mesh_head),
    .full_o  (w_mesh_full),
    .empty_o (w_mesh_empty)
  );

`ifdef NX_COMBINER_CTRL_PRIORITY_EN
  assign w_tie_grant = NX_SRC_CTRL;
`else
  assign w_tie_grant = (r_last_grant == NX_SRC_MESH) ? NX_SRC_CTRL : NX_SRC_MESH;

  // Round-robin bounds any loss streak to one slot load, so a saturated counter is a design bug.
  a_no_starvation: assert property (@(posedge clk_i) disable iff (rst_i)
    (r_ctrl_wait != WAIT_MAX) && (r_mesh_wait != WAIT_MAX));
`endif

  // NOTE: the default assignment first keeps every path assigned, so no latch is inferred.
  always_comb begin
    w_grant = NX_SRC_CTRL;
    if (!w_ctrl_empty && !w_mesh_empty) w_grant = w_tie_grant;
    else if (!w_mesh_empty)             w_grant = NX_SRC_MESH;
  end

  assign w_load     = ~r_host_valid | bus.host_ready_i;
  assign w_any      = ~w_ctrl_empty | ~w_mesh_empty;
  assign w_fire     = w_load & w_any;
  assign w_ctrl_pop = w_fire & (w_grant == NX_SRC_CTRL);
  assign w_mesh_pop = w_fire & (w_grant == NX_SRC_MESH);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_host_valid  <= 1'b0;
      r_host_data   <= '0;
      r_host_source <= NX_SRC_CTRL;
      r_last_grant  <= NX_SRC_MESH;
    end else if (w_load) begin
      r_host_valid <= w_any;
      if (w_any) begin
        r_host_data   <= (w_grant == NX_SRC_MESH) ? w_mesh_head : w_ctrl_head;
        r_host_source <= w_grant;
        r_last_grant  <= w_grant;
      end
    end
  end

  // Wait counters advance only on slot loads the source lost, so host backpressure does not count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ctrl_wait <= '0;
      r_mesh_wait <= '0;
    end else begin
      if (w_ctrl_pop)
        r_ctrl_wait <= '0;
      else if (w_fire && !w_ctrl_empty && r_ctrl_wait != WAIT_MAX)
        r_ctrl_wait <= r_ctrl_wait + WAIT_W'(1);
      if (w_mesh_pop)
        r_mesh_wait <= '0;
      else if (w_fire && !w_mesh_empty && r_mesh_wait != WAIT_MAX)
        r_mesh_wait <= r_mesh_wait + WAIT_W'(1);
    end
  end

  assign bus.ctrl_ready_o  = w_ctrl_ready;
  assign bus.mesh_ready_o  = w_mesh_ready;
  assign bus.host_data_o   = r_host_data;
  assign bus.host_source_o = r_host_source;
  assign bus.host_valid_o  = r_host_valid;
  assign bus.idle_o        = w_ctrl_empty & w_mesh_empty & ~r_host_valid;

endmodule

// File: tb/tb_nx_stream_combiner.sv
// Self-checking bench for nx_stream_combiner: per-source scoreboard queues plus directed scenarios.
// Build with NX_COMBINER_CTRL_PRIORITY_EN defined to check strict ctrl priority instead of round-robin.
module tb_nx_stream_combiner;
  import nx_constants::*;

  localparam int FIFO_DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nx_stream_combiner_if bus ();

  nx_stream_combiner #(.FIFO_DEPTH(FIFO_DEPTH), .STALL_LIMIT(255)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;
  int acc_c       = 0;
  int acc_m       = 0;

  nx_message_t send_c[$];
  nx_message_t send_m[$];
  nx_message_t exp_c[$];
  nx_message_t exp_m[$];
  logic        out_src[$];
  int          out_cyc[$];

  logic        prev_hv  = 1'b0;
  logic        prev_hr  = 1'b0;
  logic        prev_rst = 1'b1;
  nx_message_t prev_data = '0;
  nx_source_e  prev_src  = NX_SRC_CTRL;

  initial begin
    bus.ctrl_valid_i = 1'b0;
    bus.ctrl_data_i  = '0;
    bus.mesh_valid_i = 1'b0;
    bus.mesh_data_i  = '0;
    bus.host_ready_i = 1'b0;
  end

  // One clock: drive at the falling edge, sample 1ns later, account for what the next rising edge does.
  task automatic tick(input logic hr, input bit gaps, input logic r = 1'b0);
    nx_message_t want;
    @(negedge clk);
    cycle++;
    rst = r;
    bus.ctrl_valid_i = (send_c.size() > 0) && !(gaps && $urandom_range(0, 3) == 0);
    bus.ctrl_data_i  = (send_c.size() > 0) ? send_c[0] : '0;
    bus.mesh_valid_i = (send_m.size() > 0) && !(gaps && $urandom_range(0, 3) == 0);
    bus.mesh_data_i  = (send_m.size() > 0) ? send_m[0] : '0;
    bus.host_ready_i = hr;
    #1;
    if (!r && !prev_rst && prev_hv && !prev_hr) begin
      vectors++;
      if (bus.host_valid_o !== 1'b1 || bus.host_data_o !== prev_data || bus.host_source_o !== prev_src) begin
        miscompares++;
        $display("FAIL hold_stable @%0d: got v=%0b d=%h s=%0b, want v=1 d=%h s=%0b", cycle,
                 bus.host_valid_o, bus.host_data_o, bus.host_source_o, prev_data, prev_src);
      end
    end
    if (r) begin
      exp_c.delete();
      exp_m.delete();
    end else begin
      if (bus.ctrl_valid_i && bus.ctrl_ready_o) begin
        exp_c.push_back(send_c.pop_front());
        acc_c++;
      end
      if (bus.mesh_valid_i && bus.mesh_ready_o) begin
        exp_m.push_back(send_m.pop_front());
        acc_m++;
      end
      if (bus.host_valid_o === 1'b1 && hr) begin
        vectors++;
        out_src.push_back(bus.host_source_o);
        out_cyc.push_back(cycle);
        if (bus.host_source_o == NX_SRC_CTRL) begin
          if (exp_c.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_ctrl @%0d: got d=%h, want no ctrl message", cycle, bus.host_data_o);
          end else begin
            want = exp_c.pop_front();
            if (bus.host_data_o !== want) begin
              miscompares++;
              $display("FAIL scoreboard_ctrl @%0d: got d=%h, want d=%h", cycle, bus.host_data_o, want);
            end
          end
        end else begin
          if (exp_m.size() == 0) begin
            miscompares++;
            $display("FAIL scoreboard_mesh @%0d: got d=%h, want no mesh message", cycle, bus.host_data_o);
          end else begin
            want = exp_m.pop_front();
            if (bus.host_data_o !== want) begin
              miscompares++;
              $display("FAIL scoreboard_mesh @%0d: got d=%h, want d=%h", cycle, bus.host_data_o, want);
            end
          end
        end
      end
    end
    prev_hv   = bus.host_valid_o;
    prev_hr   = hr;
    prev_rst  = r;
    prev_data = bus.host_data_o;
    prev_src  = bus.host_source_o;
  endtask

  task automatic do_reset();
    send_c.delete();
    send_m.delete();
    repeat (2) tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    acc_c = 0;
    acc_m = 0;
    out_src.delete();
    out_cyc.delete();
  endtask

  task automatic test_reset();
    repeat (3) tick(1'b0, 1'b0, 1'b1);
    vectors++;
    if (bus.host_valid_o !== 1'b0 || bus.host_data_o !== '0 || bus.host_source_o !== NX_SRC_CTRL) begin
      miscompares++;
      $display("FAIL reset_slot: got v=%0b d=%h s=%0b, want v=0 d=0 s=0",
               bus.host_valid_o, bus.host_data_o, bus.host_source_o);
    end
    vectors++;
    if (bus.idle_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_idle: got %0b, want 1", bus.idle_o);
    end
    vectors++;
    if (bus.ctrl_ready_o !== 1'b0 || bus.mesh_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: got c=%0b m=%0b, want 0 0", bus.ctrl_ready_o, bus.mesh_ready_o);
    end
    tick(1'b0, 1'b0, 1'b0);
    vectors++;
    if (bus.ctrl_ready_o !== 1'b0 || bus.mesh_ready_o !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_release_early: got c=%0b m=%0b, want 0 0", bus.ctrl_ready_o, bus.mesh_ready_o);
    end
    tick(1'b0, 1'b0, 1'b0);
    vectors++;
    if (bus.ctrl_ready_o !== 1'b1 || bus.mesh_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL ready_release: got c=%0b m=%0b, want 1 1", bus.ctrl_ready_o, bus.mesh_ready_o);
    end
  endtask

  task automatic test_single();
    do_reset();
    send_c.push_back(32'h0000_00A5);
    tick(1'b1, 1'b0);
    vectors++;
    if (acc_c !== 1) begin
      miscompares++;
      $display("FAIL single_accept: got %0d accepts, want 1", acc_c);
    end
    tick(1'b1, 1'b0);
    vectors++;
    if (bus.host_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL single_latency_early: got v=%0b, want 0", bus.host_valid_o);
    end
    tick(1'b1, 1'b0);
    vectors++;
    if (bus.host_valid_o !== 1'b1 || bus.host_source_o !== NX_SRC_CTRL || bus.host_data_o !== 32'h0000_00A5) begin
      miscompares++;
      $display("FAIL single_output: got v=%0b s=%0b d=%h, want v=1 s=0 d=000000a5",
               bus.host_valid_o, bus.host_source_o, bus.host_data_o);
    end
    tick(1'b1, 1'b0);
    vectors++;
    if (bus.host_valid_o !== 1'b0 || bus.idle_o !== 1'b1) begin
      miscompares++;
      $display("FAIL single_idle: got v=%0b idle=%0b, want v=0 idle=1", bus.host_valid_o, bus.idle_o);
    end
  endtask

  task automatic test_stream();
    int start;
    logic want_src;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send_c.push_back($urandom());
      send_m.push_back($urandom());
    end
    start = cycle + 1;
    for (int i = 0; i < 40 && out_src.size() < 16; i++) tick(1'b1, 1'b0);
    vectors++;
    if (out_src.size() != 16) begin
      miscompares++;
      $display("FAIL stream_count: got %0d outputs, want 16", out_src.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
`ifdef NX_COMBINER_CTRL_PRIORITY_EN
        want_src = (i >= 8);
`else
        want_src = i[0];
`endif
        vectors++;
        if (out_src[i] !== want_src) begin
          miscompares++;
          $display("FAIL stream_order[%0d]: got src=%0b, want src=%0b", i, out_src[i], want_src);
        end
      end
      vectors++;
      if (out_cyc[0] - start != 2 || out_cyc[15] - start > 17) begin
        miscompares++;
        $display("FAIL stream_timing: got first=%0d last=%0d, want first=2 last<=17",
                 out_cyc[0] - start, out_cyc[15] - start);
      end
    end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      send_c.push_back($urandom());
      send_m.push_back($urandom());
    end
    repeat (10) tick(1'b0, 1'b0);
    vectors++;
    if (acc_c != FIFO_DEPTH + 1 || acc_m != FIFO_DEPTH) begin
      miscompares++;
      $display("FAIL bp_accepts: got c=%0d m=%0d, want c=%0d m=%0d", acc_c, acc_m, FIFO_DEPTH + 1, FIFO_DEPTH);
    end
    vectors++;
    if (bus.ctrl_ready_o !== 1'b0 || bus.mesh_ready_o !== 1'b0 || bus.host_valid_o !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_stalled: got rc=%0b rm=%0b v=%0b, want 0 0 1",
               bus.ctrl_ready_o, bus.mesh_ready_o, bus.host_valid_o);
    end
    n = 0;
    while (n < 100 && (send_c.size() + send_m.size() + exp_c.size() + exp_m.size() != 0 || bus.host_valid_o)) begin
      tick(1'b1, 1'b0);
      n++;
    end
    vectors++;
    if (n >= 100 || out_src.size() != 12) begin
      miscompares++;
      $display("FAIL bp_drain: got %0d outputs in %0d cycles, want 12 within 100", out_src.size(), n);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    do_reset();
    for (int i = 0; i < 3; i++) send_c.push_back($urandom());
    for (int i = 0; i < 10 && send_c.size() > 0; i++) tick(1'b0, 1'b0);
    vectors++;
    if (acc_c != 3) begin
      miscompares++;
      $display("FAIL rstmid_buffered: got %0d accepts, want 3", acc_c);
    end
    tick(1'b0, 1'b0, 1'b1);
    tick(1'b0, 1'b0, 1'b0);
    vectors++;
    if (bus.host_valid_o !== 1'b0 || bus.idle_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_state: got v=%0b idle=%0b, want v=0 idle=1", bus.host_valid_o, bus.idle_o);
    end
    n = out_src.size();
    repeat (10) tick(1'b1, 1'b0);
    vectors++;
    if (out_src.size() != n || bus.ctrl_ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_flush: got %0d late outputs ready=%0b, want 0 late outputs ready=1",
               out_src.size() - n, bus.ctrl_ready_o);
    end
  endtask

  task automatic test_random(input int ready_pct);
    int n;
    do_reset();
    for (int i = 0; i < 40; i++) begin
      send_c.push_back($urandom());
      send_m.push_back($urandom());
    end
    n = 0;
    while (n < 2000 && (send_c.size() + send_m.size() + exp_c.size() + exp_m.size() != 0 || bus.host_valid_o)) begin
      tick(($urandom_range(0, 99) < ready_pct), 1'b1);
      n++;
    end
    tick(1'b1, 1'b0);
    vectors++;
    if (n >= 2000 || out_src.size() != 80 || bus.idle_o !== 1'b1) begin
      miscompares++;
      $display("FAIL random_drain(pct=%0d): got %0d outputs idle=%0b in %0d cycles, want 80 idle=1",
               ready_pct, out_src.size(), bus.idle_o, n);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_reset_mid();
    test_random(70);
    test_random(30);
    test_random(100);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
